// File: rtl/synth_pkg.sv
// Shared definitions for the sample loader and the sample playback ROM.
package synth_pkg;

    localparam logic [7:0]  SYNC_BYTE            = 8'hA5;
    localparam int unsigned SAMPLE_WIDTH_DEFAULT = 8;
    localparam int unsigned SAMPLE_SIZE_DEFAULT  = 512;

    typedef enum logic [3:0] {
        StIdle,
        StAddrHi,
        StAddrLo,
        StLenHi,
        StLenLo,
        StData,
        StCsum,
        StFin,
        StFail
    } state_e;

endpackage

// File: rtl/sample_loader.sv
// Byte-stream frame parser that writes payload bytes into the sample memory.
// Define SAMPLE_LOADER_CHECKSUM_EN to require a trailing two's-complement checksum byte.
module sample_loader
    import synth_pkg::*;
#(
    parameter int unsigned SAMPLE_WIDTH = SAMPLE_WIDTH_DEFAULT,
    parameter int unsigned SAMPLE_SIZE  = SAMPLE_SIZE_DEFAULT,
    parameter int unsigned ADDR_WIDTH   = 9
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [7:0]              in_data,
    output logic                    in_ready,
    output logic                    wr_en,
    output logic [ADDR_WIDTH-1:0]   wr_addr,
    output logic [SAMPLE_WIDTH-1:0] wr_data,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

`ifdef SAMPLE_LOADER_CHECKSUM_EN
    localparam state_e DataEnd = StCsum;
    logic [7:0] sum_q, sum_d;
`else
    localparam state_e DataEnd = StFin;
`endif

    state_e                  state_q, state_d;
    logic                    in_ready_q, in_ready_d;
    logic                    wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [SAMPLE_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [15:0]             addr_q, addr_d;
    logic [7:0]              len_hi_q, len_hi_d;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
    logic [15:0]             count_q, count_d;
    logic                    accept;
    logic [15:0]             len_full;
    logic [16:0]             end_addr;

    assign accept   = in_valid && in_ready_q;
    assign len_full = {len_hi_q, in_data};
    // 17-bit sum so a 16-bit address plus length cannot overflow the range check
    assign end_addr = {1'b0, addr_q} + {1'b0, len_full};

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_hi_d  = len_hi_q;
        ptr_d     = ptr_q;
        count_d   = count_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
`ifdef SAMPLE_LOADER_CHECKSUM_EN
        sum_d     = sum_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (accept && in_data == SYNC_BYTE) state_d = StAddrHi;
            end
            StAddrHi: begin
                if (accept) begin
                    addr_d[15:8] = in_data;
                    state_d      = StAddrLo;
                end
            end
            StAddrLo: begin
                if (accept) begin
                    addr_d[7:0] = in_data;
                    state_d     = StLenHi;
                end
            end
            StLenHi: begin
                if (accept) begin
                    len_hi_d = in_data;
                    state_d  = StLenLo;
                end
            end
            StLenLo: begin
                if (accept) begin
`ifdef SAMPLE_LOADER_CHECKSUM_EN
                    sum_d = 8'd0;
`endif
                    if (end_addr > 17'(SAMPLE_SIZE)) begin
                        state_d = StFail;
                    end else if (len_full == 16'd0) begin
                        state_d = DataEnd;
                    end else begin
                        ptr_d   = addr_q[ADDR_WIDTH-1:0];
                        count_d = len_full;
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = ptr_q;
                    wr_data_d = SAMPLE_WIDTH'(in_data);
                    ptr_d     = ptr_q + ADDR_WIDTH'(1);
                    count_d   = count_q - 16'd1;
`ifdef SAMPLE_LOADER_CHECKSUM_EN
                    sum_d     = sum_q + in_data;
`endif
                    if (count_q == 16'd1) state_d = DataEnd;
                end
            end
`ifdef SAMPLE_LOADER_CHECKSUM_EN
            StCsum: begin
                if (accept) begin
                    state_d = (8'(sum_q + in_data) == 8'd0) ? StFin : StFail;
                end
            end
`endif
            StFin:   state_d = StIdle;
            StFail:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        in_ready_d = (state_d != StFin) && (state_d != StFail);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            addr_q     <= '0;
            len_hi_q   <= '0;
            ptr_q      <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            addr_q     <= addr_d;
            len_hi_q   <= len_hi_d;
            ptr_q      <= ptr_d;
            count_q    <= count_d;
        end
    end

`ifdef SAMPLE_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sum_q <= '0;
        else     sum_q <= sum_d;
    end
`endif

    assign in_ready = in_ready_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StFin);
    assign err      = (state_q == StFail);

endmodule

// File: tb/tb_sample_loader.sv
// Self-checking bench for sample_loader: frame-level reference model plus literal scenario results.
// Honours SAMPLE_LOADER_CHECKSUM_EN the same way as the design.
module tb_sample_loader;

    localparam int AW = 9;
`ifdef SAMPLE_LOADER_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready, wr_en, busy, done, err;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;

    always #5 clk = ~clk;

    sample_loader dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: what the outputs must show in the window after each clock edge.
    logic          m_ready, m_busy, m_done, m_err, m_wr_en, m_acc;
    logic [AW-1:0] m_wr_addr;
    logic [7:0]    m_wr_data;
    bit            m_in_frame, m_csum_phase;
    int            m_nhdr, m_addr, m_len, m_idx;
    logic [7:0]    m_hdr [4];
    logic [7:0]    m_sum;

    logic [16:0]   wlog [$];
    int            n_done = 0;
    int            n_err  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_ready = 0; m_busy = 0; m_done = 0; m_err = 0; m_wr_en = 0; m_acc = 0;
        m_wr_addr = '0; m_wr_data = '0;
        m_in_frame = 0; m_csum_phase = 0;
        m_nhdr = 0; m_addr = 0; m_len = 0; m_idx = 0; m_sum = 8'h00;
    endtask

    task automatic end_data();
        if (CSUM) begin
            m_csum_phase = 1;
        end else begin
            m_done     = 1;
            m_in_frame = 0;
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        logic [7:0] s;
        if (!m_in_frame) begin
            if (b == 8'hA5) begin
                m_in_frame   = 1;
                m_nhdr       = 0;
                m_csum_phase = 0;
            end
        end else if (m_nhdr < 4) begin
            m_hdr[m_nhdr] = b;
            m_nhdr++;
            if (m_nhdr == 4) begin
                m_addr = int'({m_hdr[0], m_hdr[1]});
                m_len  = int'({m_hdr[2], m_hdr[3]});
                m_idx  = 0;
                m_sum  = 8'h00;
                if (m_addr + m_len > 512) begin
                    m_err      = 1;
                    m_in_frame = 0;
                end else if (m_len == 0) begin
                    end_data();
                end
            end
        end else if (m_csum_phase) begin
            s = m_sum + b;
            if (s == 8'h00) m_done = 1;
            else            m_err  = 1;
            m_in_frame   = 0;
            m_csum_phase = 0;
        end else begin
            m_wr_en   = 1;
            m_wr_addr = AW'(m_addr + m_idx);
            m_wr_data = b;
            m_sum     = m_sum + b;
            m_idx++;
            if (m_idx == m_len) end_data();
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            model_reset();
            return;
        end
        m_acc   = in_valid && m_ready;
        m_wr_en = 0;
        m_done  = 0;
        m_err   = 0;
        if (m_acc) model_byte(in_data);
        m_ready = !(m_done || m_err);
        m_busy  = m_in_frame || m_done || m_err;
    endtask

    task automatic check_outputs();
        chk("in_ready", 32'(in_ready), 32'(m_ready));
        chk("busy",     32'(busy),     32'(m_busy));
        chk("done",     32'(done),     32'(m_done));
        chk("err",      32'(err),      32'(m_err));
        chk("wr_en",    32'(wr_en),    32'(m_wr_en));
        if (m_wr_en) begin
            chk("wr_addr", 32'(wr_addr), 32'(m_wr_addr));
            chk("wr_data", 32'(wr_data), 32'(m_wr_data));
        end
        if (wr_en) wlog.push_back({wr_addr, wr_data});
        if (done) n_done++;
        if (err)  n_err++;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit got;
        got      = 0;
        in_valid = 1'b0;
        repeat (gap) step();
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 8 && !got; i++) begin
            step();
            got = m_acc;
        end
        in_valid = 1'b0;
        if (!got) chk("accept_timeout", 32'(0), 32'(1));
    endtask

    task automatic send_frame(input logic [7:0] f [$], input int gap);
        foreach (f[i]) send_byte(f[i], gap);
    endtask

    task automatic end_scn(input string name, input logic [16:0] ew [$], input int ed,
                           input int ee);
        repeat (4) step();
        chk({name, "_nwrites"}, 32'(wlog.size()), 32'(ew.size()));
        foreach (ew[i]) begin
            if (i < wlog.size()) chk({name, "_write"}, 32'(wlog[i]), 32'(ew[i]));
        end
        chk({name, "_ndone"}, 32'(n_done), 32'(ed));
        chk({name, "_nerr"},  32'(n_err),  32'(ee));
        wlog.delete();
        n_done = 0;
        n_err  = 0;
    endtask

    initial begin
        logic [7:0]  f  [$];
        logic [7:0]  f2 [$];
        logic [16:0] ew [$];

        model_reset();
        rst = 1'b1;
        step();
        step();
        chk("rst_in_ready", 32'(in_ready), 32'(0));
        chk("rst_busy",     32'(busy),     32'(0));
        chk("rst_wr_addr",  32'(wr_addr),  32'(0));
        chk("rst_wr_data",  32'(wr_data),  32'(0));
        rst = 1'b0;
        step();
        chk("ready_after_rst", 32'(in_ready), 32'(1));
        wlog.delete(); n_done = 0; n_err = 0;

        // Basic three-byte load
        f = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33};
        if (CSUM) f.push_back(8'h9A);
        send_frame(f, 0);
        ew = '{{9'h010, 8'h11}, {9'h011, 8'h22}, {9'h012, 8'h33}};
        end_scn("basic", ew, 1, 0);

        // Range overflow: trailing data bytes fall back into idle
        f = '{8'hA5, 8'h01, 8'hFE, 8'h00, 8'h03, 8'h44, 8'h55, 8'h66};
        send_frame(f, 0);
        ew = '{};
        end_scn("overflow", ew, 0, 1);

        // Last-address write, then a zero-length frame back to back
        f = '{8'hA5, 8'h01, 8'hFF, 8'h00, 8'h01, 8'h7F};
        if (CSUM) f.push_back(8'h81);
        f2 = '{8'hA5, 8'h00, 8'h05, 8'h00, 8'h00};
        if (CSUM) f2.push_back(8'h00);
        send_frame(f, 0);
        send_frame(f2, 0);
        ew = '{{9'h1FF, 8'h7F}};
        end_scn("top_addr", ew, 2, 0);

        // Bad checksum when enabled; trailing 00 ignored otherwise
        f = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h02, 8'h01, 8'h02, 8'h00};
        send_frame(f, 0);
        ew = '{{9'h000, 8'h01}, {9'h001, 8'h02}};
        end_scn("bad_csum", ew, CSUM ? 0 : 1, CSUM ? 1 : 0);

        // Garbage prefix and valid gaps
        f = '{8'h00, 8'hFF, 8'hA4};
        send_frame(f, 0);
        f = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33};
        if (CSUM) f.push_back(8'h9A);
        send_frame(f, 2);
        ew = '{{9'h010, 8'h11}, {9'h011, 8'h22}, {9'h012, 8'h33}};
        end_scn("gaps", ew, 1, 0);

        // Reset in the middle of the data phase
        f = '{8'hA5, 8'h00, 8'h20, 8'h00, 8'h04, 8'hAA, 8'hBB};
        send_frame(f, 0);
        #2 rst = 1'b1;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'(0));
        chk("midrst_wr_en",    32'(wr_en),    32'(0));
        chk("midrst_wr_addr",  32'(wr_addr),  32'(0));
        chk("midrst_wr_data",  32'(wr_data),  32'(0));
        chk("midrst_busy",     32'(busy),     32'(0));
        model_reset();
        step();
        step();
        rst = 1'b0;
        ew = '{{9'h020, 8'hAA}, {9'h021, 8'hBB}};
        end_scn("midrst", ew, 0, 0);

        f = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33};
        if (CSUM) f.push_back(8'h9A);
        send_frame(f, 0);
        ew = '{{9'h010, 8'h11}, {9'h011, 8'h22}, {9'h012, 8'h33}};
        end_scn("post_rst", ew, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
